// File: rtl/bus_datapath_seq_pkg.sv
// Shared types for the sequenced bus datapath: ALU opcodes, sequencer states, opcode legality.
// BUS_DATAPATH_MUL_EN enables the MUL opcode and the extra EXEC2 sequencer state.
package dp_pkg;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_SHL  = 4'd4,
        OP_SHR  = 4'd5,
        OP_SHRA = 4'd6,
        OP_ROL  = 4'd7,
        OP_ROR  = 4'd8,
        OP_NEG  = 4'd9,
        OP_NOT  = 4'd10,
        OP_MUL  = 4'd11
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOADY = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WRITE = 3'd3
`ifdef BUS_DATAPATH_MUL_EN
        , ST_EXEC2 = 3'd4
`endif
    } state_t;

`ifdef BUS_DATAPATH_MUL_EN
    localparam logic [3:0] OP_LAST_LEGAL = 4'd11;
`else
    localparam logic [3:0] OP_LAST_LEGAL = 4'd10;
`endif

    function automatic logic op_legal(input logic [3:0] op);
        return op <= OP_LAST_LEGAL;
    endfunction

endpackage

// File: rtl/bus_datapath_seq_if.sv
// Control-unit <-> execution-unit bus: instruction request, external load port and results.
// hi_out exists only when BUS_DATAPATH_MUL_EN is defined.
interface dp_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = 4
);
    logic             start;
    logic [3:0]       op;
    logic [AW-1:0]    ra;
    logic [AW-1:0]    rb;
    logic [AW-1:0]    rc;
    logic             use_imm;
    logic [WIDTH-1:0] imm;
    logic             ld_en;
    logic [AW-1:0]    ld_addr;
    logic [WIDTH-1:0] ld_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             z_flag;
    logic             c_flag;
    logic             err;
`ifdef BUS_DATAPATH_MUL_EN
    logic [WIDTH-1:0] hi_out;
`endif

    modport master (
        output start, op, ra, rb, rc, use_imm, imm, ld_en, ld_addr, ld_data,
        input  busy, done, result, z_flag, c_flag,
`ifdef BUS_DATAPATH_MUL_EN
        input  hi_out,
`endif
        input  err
    );

    modport slave (
        input  start, op, ra, rb, rc, use_imm, imm, ld_en, ld_addr, ld_data,
        output busy, done, result, z_flag, c_flag,
`ifdef BUS_DATAPATH_MUL_EN
        output hi_out,
`endif
        output err
    );

endinterface

// File: rtl/bus_datapath_seq_alu.sv
// Combinational multi-op ALU: y = a op b, with carry/not-borrow and zero flags.
// BUS_DATAPATH_MUL_EN adds the unsigned multiply and its high-half output.
module dp_alu
    import dp_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_t              op,
    output logic [WIDTH-1:0] y,
`ifdef BUS_DATAPATH_MUL_EN
    output logic [WIDTH-1:0] hi,
`endif
    output logic             cout,
    output logic             zero
);
    localparam int unsigned AW_SH = $clog2(WIDTH);

    logic [AW_SH-1:0] amt;
    logic [WIDTH:0]   add_s;
    logic [WIDTH:0]   sub_s;

    assign amt   = b[AW_SH-1:0];
    assign add_s = {1'b0, a} + {1'b0, b};
    // Subtract as a + ~b + 1 so the carry-out reads as "no borrow".
    assign sub_s = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);

`ifdef BUS_DATAPATH_MUL_EN
    logic [2*WIDTH-1:0] prod;
    assign prod = (2*WIDTH)'(a) * (2*WIDTH)'(b);
`endif

    always_comb begin
        y    = '0;
        cout = 1'b0;
`ifdef BUS_DATAPATH_MUL_EN
        hi   = '0;
`endif
        case (op)
            OP_ADD:  begin y = add_s[WIDTH-1:0]; cout = add_s[WIDTH]; end
            OP_SUB:  begin y = sub_s[WIDTH-1:0]; cout = sub_s[WIDTH]; end
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_SHL:  y = a << amt;
            OP_SHR:  y = a >> amt;
            OP_SHRA: y = $unsigned($signed(a) >>> amt);
            OP_ROL:  y = (a << amt) | (a >> (WIDTH - amt));
            OP_ROR:  y = (a >> amt) | (a << (WIDTH - amt));
            OP_NEG:  y = ~b + WIDTH'(1);
            OP_NOT:  y = ~b;
`ifdef BUS_DATAPATH_MUL_EN
            OP_MUL:  begin
                y    = prod[WIDTH-1:0];
                hi   = prod[2*WIDTH-1:WIDTH];
                cout = |prod[2*WIDTH-1:WIDTH];
            end
`endif
            default: y = '0;
        endcase
    end

    assign zero = (y == '0);

endmodule

// File: rtl/bus_datapath_seq.sv
// Sequenced execution unit: register file, Y/Z registers and a Y<=Ra; Z<=Y op B; Rc<=Z sequencer.
// BUS_DATAPATH_MUL_EN adds MUL (extra EXEC2 cycle) and the hi_out port.
module bus_datapath_seq
    import dp_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned NUM_REGS = 16
) (
    input  logic clk,
    input  logic clear,
    dp_if.slave  bus
);
    localparam int unsigned AW = $clog2(NUM_REGS);

    state_t           state_q;
    logic [WIDTH-1:0] regs_q [NUM_REGS];
    logic [WIDTH-1:0] y_q, z_q, imm_q, result_q;
    op_t              op_q;
    logic [AW-1:0]    ra_q, rb_q, rc_q;
    logic             use_imm_q, z_flag_q, c_flag_q, done_q, err_q;

    logic [WIDTH-1:0] alu_b, alu_y;
    logic             alu_cout, alu_zero;
`ifdef BUS_DATAPATH_MUL_EN
    logic [WIDTH-1:0] alu_hi, prod_lo_q, prod_hi_q, hi_q;
`endif

    assign alu_b = use_imm_q ? imm_q : regs_q[rb_q];

    dp_alu #(.WIDTH(WIDTH)) u_alu (
        .a    (y_q),
        .b    (alu_b),
        .op   (op_q),
        .y    (alu_y),
`ifdef BUS_DATAPATH_MUL_EN
        .hi   (alu_hi),
`endif
        .cout (alu_cout),
        .zero (alu_zero)
    );

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_q   <= ST_IDLE;
            for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
            y_q       <= '0;
            z_q       <= '0;
            imm_q     <= '0;
            result_q  <= '0;
            op_q      <= OP_ADD;
            ra_q      <= '0;
            rb_q      <= '0;
            rc_q      <= '0;
            use_imm_q <= 1'b0;
            z_flag_q  <= 1'b0;
            c_flag_q  <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef BUS_DATAPATH_MUL_EN
            prod_lo_q <= '0;
            prod_hi_q <= '0;
            hi_q      <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    // External load and instruction accept may share an edge.
                    if (bus.ld_en) regs_q[bus.ld_addr] <= bus.ld_data;
                    if (bus.start) begin
                        if (op_legal(bus.op)) begin
                            op_q      <= op_t'(bus.op);
                            ra_q      <= bus.ra;
                            rb_q      <= bus.rb;
                            rc_q      <= bus.rc;
                            use_imm_q <= bus.use_imm;
                            imm_q     <= bus.imm;
                            state_q   <= ST_LOADY;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_LOADY: begin
                    y_q     <= regs_q[ra_q];
                    state_q <= ST_EXEC;
                end
                ST_EXEC: begin
`ifdef BUS_DATAPATH_MUL_EN
                    if (op_q == OP_MUL) begin
                        prod_lo_q <= alu_y;
                        prod_hi_q <= alu_hi;
                        state_q   <= ST_EXEC2;
                    end else
`endif
                    begin
                        z_q      <= alu_y;
                        z_flag_q <= alu_zero;
                        c_flag_q <= alu_cout;
                        state_q  <= ST_WRITE;
                    end
                end
`ifdef BUS_DATAPATH_MUL_EN
                ST_EXEC2: begin
                    z_q      <= prod_lo_q;
                    hi_q     <= prod_hi_q;
                    z_flag_q <= (prod_lo_q == '0);
                    c_flag_q <= |prod_hi_q;
                    state_q  <= ST_WRITE;
                end
`endif
                ST_WRITE: begin
                    regs_q[rc_q] <= z_q;
                    result_q     <= z_q;
                    done_q       <= 1'b1;
                    state_q      <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy   = (state_q != ST_IDLE);
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.z_flag = z_flag_q;
    assign bus.c_flag = c_flag_q;
    assign bus.err    = err_q;
`ifdef BUS_DATAPATH_MUL_EN
    assign bus.hi_out = hi_q;
`endif

endmodule

// File: tb/tb_bus_datapath_seq.sv
// Scoreboard bench for bus_datapath_seq: expected write-backs are queued at issue and
// checked when done pulses. Define BUS_DATAPATH_MUL_EN to also exercise MUL/hi_out.
module tb_bus_datapath_seq;
    import dp_pkg::*;

    typedef struct {
        string       name;
        logic [31:0] res;
        logic        z;
        logic        c;
        logic [31:0] hi;
        int          start;
        int          lat;
    } exp_t;

    logic clk = 1'b0;
    logic clear;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   done_cnt = 0;
    exp_t sb[$];

    dp_if #(.WIDTH(32), .AW(4)) bus ();

    bus_datapath_seq #(.WIDTH(32), .NUM_REGS(16)) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write-back monitor, sampled on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (!clear && bus.done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("spurious_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                check({e.name, ".result"}, 64'(bus.result), 64'(e.res));
                check({e.name, ".z_flag"}, 64'(bus.z_flag), 64'(e.z));
                check({e.name, ".c_flag"}, 64'(bus.c_flag), 64'(e.c));
                check({e.name, ".latency"}, 64'(cyc - e.start), 64'(e.lat));
`ifdef BUS_DATAPATH_MUL_EN
                check({e.name, ".hi_out"}, 64'(bus.hi_out), 64'(e.hi));
`endif
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input string name, input logic [31:0] res, input logic z, input logic c,
                        input int start, input int lat, input logic [31:0] hi);
        exp_t e;
        e.name = name; e.res = res; e.z = z; e.c = c;
        e.start = start; e.lat = lat; e.hi = hi;
        sb.push_back(e);
    endtask

    task automatic ld(input logic [3:0] a, input logic [31:0] d);
        bus.ld_en = 1'b1; bus.ld_addr = a; bus.ld_data = d;
        tick();
        bus.ld_en = 1'b0;
    endtask

    task automatic start_instr(input string name, input logic [3:0] op,
                               input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc,
                               input logic ui, input logic [31:0] imm,
                               input logic [31:0] res, input logic z, input logic c,
                               input logic [31:0] hi = 32'h0);
        bus.start = 1'b1; bus.op = op; bus.ra = ra; bus.rb = rb; bus.rc = rc;
        bus.use_imm = ui; bus.imm = imm;
        push(name, res, z, c, cyc + 1, (op == 4'(OP_MUL)) ? 4 : 3, hi);
        tick();
        bus.start = 1'b0;
        bus.ld_en = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (sb.size() == 0 && !bus.busy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) begin
            check("timeout_pending", 64'(sb.size()), 64'd0);
            sb.delete();
        end
    endtask

    task automatic issue(input string name, input logic [3:0] op,
                         input logic [3:0] ra, input logic [3:0] rb, input logic [3:0] rc,
                         input logic ui, input logic [31:0] imm,
                         input logic [31:0] res, input logic z, input logic c,
                         input logic [31:0] hi = 32'h0);
        start_instr(name, op, ra, rb, rc, ui, imm, res, z, c, hi);
        wait_idle();
    endtask

    // Reads R[a] by OR-ing with immediate 0 into R15.
    task automatic rd(input string name, input logic [3:0] a, input logic [31:0] exp);
        issue(name, 4'(OP_OR), a, 4'd0, 4'd15, 1'b1, 32'h0, exp, exp == 32'h0, 1'b0);
    endtask

    initial begin
        int d0;
        clear = 1'b1;
        bus.start = 1'b0; bus.op = 4'd0; bus.ra = '0; bus.rb = '0; bus.rc = '0;
        bus.use_imm = 1'b0; bus.imm = '0; bus.ld_en = 1'b0; bus.ld_addr = '0; bus.ld_data = '0;
        repeat (2) tick();
        check("rst_busy", 64'(bus.busy), 64'd0);
        check("rst_done", 64'(bus.done), 64'd0);
        check("rst_result", 64'(bus.result), 64'd0);
        clear = 1'b0;
        tick();

        // Preloaded state is wiped by clear.
        ld(4'd5, 32'h55);
        issue("pre_or", 4'(OP_OR), 4'd5, 4'd0, 4'd6, 1'b1, 32'h0, 32'h55, 1'b0, 1'b0);
        clear = 1'b1;
        #1;
        check("clr_result", 64'(bus.result), 64'd0);
        check("clr_zc", 64'({bus.z_flag, bus.c_flag}), 64'd0);
        check("clr_busy_err", 64'({bus.busy, bus.err, bus.done}), 64'd0);
        tick();
        clear = 1'b0;
        rd("rd_r5_cleared", 4'd5, 32'h0);

        ld(4'd1, 32'd5);
        ld(4'd2, 32'd7);
        issue("add", 4'(OP_ADD), 4'd1, 4'd2, 4'd3, 1'b0, 32'h0, 32'd12, 1'b0, 1'b0);
        rd("rd_r3", 4'd3, 32'd12);

        ld(4'd1, 32'd3);
        ld(4'd2, 32'd3);
        issue("sub_zero", 4'(OP_SUB), 4'd1, 4'd2, 4'd1, 1'b0, 32'h0, 32'h0, 1'b1, 1'b1);
        issue("sub_borrow", 4'(OP_SUB), 4'd1, 4'd0, 4'd7, 1'b1, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);

        ld(4'd1, 32'h8000_0001);
        issue("shra", 4'(OP_SHRA), 4'd1, 4'd0, 4'd7, 1'b1, 32'd1, 32'hC000_0000, 1'b0, 1'b0);
        issue("rol", 4'(OP_ROL), 4'd1, 4'd0, 4'd7, 1'b1, 32'd4, 32'h0000_0018, 1'b0, 1'b0);
        issue("shl_amt0", 4'(OP_SHL), 4'd1, 4'd0, 4'd7, 1'b1, 32'd32, 32'h8000_0001, 1'b0, 1'b0);
        issue("shr", 4'(OP_SHR), 4'd1, 4'd0, 4'd7, 1'b1, 32'd1, 32'h4000_0000, 1'b0, 1'b0);
        issue("ror", 4'(OP_ROR), 4'd1, 4'd0, 4'd7, 1'b1, 32'd4, 32'h1800_0000, 1'b0, 1'b0);
        issue("and", 4'(OP_AND), 4'd1, 4'd0, 4'd7, 1'b1, 32'hF, 32'h1, 1'b0, 1'b0);
        issue("neg", 4'(OP_NEG), 4'd1, 4'd0, 4'd7, 1'b1, 32'd1, 32'hFFFF_FFFF, 1'b0, 1'b0);
        issue("not", 4'(OP_NOT), 4'd1, 4'd0, 4'd7, 1'b1, 32'h0F0F_0F0F, 32'hF0F0_F0F0, 1'b0, 1'b0);

        ld(4'd8, 32'hFFFF_FFFF);
        issue("add_carry", 4'(OP_ADD), 4'd8, 4'd0, 4'd7, 1'b1, 32'd1, 32'h0, 1'b1, 1'b1);

        // Load and start on the same edge: LOADY sees the new value.
        bus.ld_en = 1'b1; bus.ld_addr = 4'd9; bus.ld_data = 32'h1234;
        issue("ld_start", 4'(OP_ADD), 4'd9, 4'd0, 4'd9, 1'b1, 32'd1, 32'h1235, 1'b0, 1'b0);

        // start held for 8 edges: accepted at the first and fifth only.
        ld(4'd4, 32'd1);
        d0 = done_cnt;
        push("b2b_0", 32'd2, 1'b0, 1'b0, cyc + 1, 3, 32'h0);
        push("b2b_1", 32'd3, 1'b0, 1'b0, cyc + 5, 3, 32'h0);
        bus.start = 1'b1; bus.op = 4'(OP_ADD); bus.ra = 4'd4; bus.rc = 4'd4;
        bus.use_imm = 1'b1; bus.imm = 32'd1;
        repeat (8) tick();
        bus.start = 1'b0;
        wait_idle();
        check("b2b_done_count", 64'(done_cnt - d0), 64'd2);
        rd("rd_r4", 4'd4, 32'd3);

        // Illegal opcodes pulse err and never leave IDLE.
        d0 = done_cnt;
        bus.start = 1'b1; bus.op = 4'd13;
        tick();
        bus.start = 1'b0;
        check("ill13_err", 64'(bus.err), 64'd1);
        check("ill13_busy", 64'(bus.busy), 64'd0);
        tick();
        check("ill13_err_pulse", 64'(bus.err), 64'd0);
`ifndef BUS_DATAPATH_MUL_EN
        bus.start = 1'b1; bus.op = 4'(OP_MUL);
        tick();
        bus.start = 1'b0;
        check("ill11_err", 64'(bus.err), 64'd1);
        check("ill11_busy", 64'(bus.busy), 64'd0);
        tick();
`endif
        check("ill_no_done", 64'(done_cnt - d0), 64'd0);

        // External load while busy is dropped.
        start_instr("ld_busy", 4'(OP_OR), 4'd10, 4'd0, 4'd11, 1'b1, 32'h0, 32'h0, 1'b1, 1'b0);
        bus.ld_en = 1'b1; bus.ld_addr = 4'd10; bus.ld_data = 32'hDEAD;
        tick();
        bus.ld_en = 1'b0;
        wait_idle();
        rd("rd_r10", 4'd10, 32'h0);

        // clear during EXEC aborts the instruction with no write-back.
        d0 = done_cnt;
        bus.start = 1'b1; bus.op = 4'(OP_ADD); bus.ra = 4'd4; bus.rb = 4'd4; bus.rc = 4'd12;
        bus.use_imm = 1'b0;
        tick();
        bus.start = 1'b0;
        tick();
        check("abort_busy_before", 64'(bus.busy), 64'd1);
        clear = 1'b1;
        #1;
        check("abort_busy_after", 64'(bus.busy), 64'd0);
        tick();
        clear = 1'b0;
        repeat (6) tick();
        check("abort_no_done", 64'(done_cnt - d0), 64'd0);
        rd("rd_r12", 4'd12, 32'h0);

`ifdef BUS_DATAPATH_MUL_EN
        ld(4'd1, 32'hFFFF_FFFF);
        issue("mul", 4'(OP_MUL), 4'd1, 4'd0, 4'd7, 1'b1, 32'd2, 32'hFFFF_FFFE, 1'b0, 1'b1, 32'h1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
